// File: rtl/log_dumper_if.sv
// FIFO read side and byte-transmitter handshake grouped for the log dumper.
interface log_dumper_if #(
  parameter int DATA_WIDTH = 36
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  fifo_empty, fifo_valid, fifo_dout, tx_ready,
    output fifo_rd_en, tx_data, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_dout, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid
  );
endinterface

// File: rtl/log_dumper.sv
// Drains a log FIFO entry by entry and streams each entry MSB byte first.
// Optional LOG_DUMP_FRAME_EN prefixes every entry with an 8'hA5 header byte.
module log_dumper #(
  parameter int DATA_WIDTH = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_start,
  log_dumper_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] entry_cnt
);
  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int SHW    = NBYTES * 8;
  localparam int IDX_W  = $clog2(NBYTES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HDR, SEND} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             rd_en_c, txv_c, done_c;
  logic [7:0]       txd_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_en_c = 1'b0;
    txv_c   = 1'b0;
    txd_c   = 8'h00;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = FETCH;
          cnt_d   = 16'd0;
        end
      end
      FETCH: begin
        if (bus.fifo_empty) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en_c = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.fifo_valid) begin
          shreg_d = SHW'(bus.fifo_dout);
          idx_d   = '0;
`ifdef LOG_DUMP_FRAME_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef LOG_DUMP_FRAME_EN
      HDR: begin
        txv_c = 1'b1;
        txd_c = 8'hA5;
        if (bus.tx_ready) state_d = SEND;
      end
`endif
      SEND: begin
        txv_c = 1'b1;
        txd_c = shreg_q[SHW-1 -: 8];
        if (bus.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = sat_inc(cnt_q);
            state_d = FETCH;
          end else begin
            // Shifting keeps the outgoing byte at a fixed slice.
            shreg_d = shreg_q << 8;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Outputs are forced low while rst is held, ahead of the state register clearing.
  assign bus.fifo_rd_en = rd_en_c & ~rst;
  assign bus.tx_valid   = txv_c & ~rst;
  assign bus.tx_data    = rst ? 8'h00 : txd_c;
  assign done           = done_c & ~rst;
  assign busy           = (state_q != IDLE) & ~rst;
  assign entry_cnt      = cnt_q;
endmodule

// File: tb/tb_log_dumper.sv
// Scoreboard bench for log_dumper: FIFO/transmitter model plus queued expected bytes.
module tb_log_dumper;
  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start;
  logic        busy;
  logic        done;
  logic [15:0] entry_cnt;

  always #5 clk = ~clk;

  log_dumper_if #(.DATA_WIDTH(36)) bus_if();

  log_dumper #(.DATA_WIDTH(36)) dut (
    .clk       (clk),
    .rst       (rst),
    .dump_start(dump_start),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .entry_cnt (entry_cnt)
  );

`ifdef LOG_DUMP_FRAME_EN
  localparam int FRAME = 1;
`else
  localparam int FRAME = 0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [35:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int done_cnt = 0, seen = 0, busy_cyc = 0, txv_cyc = 0, rd_cnt = 0;
  bit ready_toggle = 1'b0;
  bit pend = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pushes an optional header byte then the first n bytes of a hand-written 5-byte list.
  task automatic push_entry(input logic [39:0] bytes, input int n);
    logic [39:0] b;
    b = bytes;
    if (FRAME != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < n; i++) exp_q.push_back(b[39-8*i -: 8]);
  endtask

  task automatic pulse_start();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_seen(input int target, input int budget);
    int n;
    n = 0;
    while (seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_bytes_seen", 64'(seen >= target), 64'd1);
  endtask

  // Model: drives FIFO/transmitter inputs at negedge+2, samples DUT at negedge+3.
  initial begin
    bus_if.fifo_empty = 1'b1;
    bus_if.fifo_valid = 1'b0;
    bus_if.fifo_dout  = '0;
    bus_if.tx_ready   = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      bus_if.fifo_valid = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (fifo_q.size() != 0) begin
          bus_if.fifo_dout  = fifo_q.pop_front();
          bus_if.fifo_valid = 1'b1;
        end
      end
      bus_if.fifo_empty = (fifo_q.size() == 0);
      if (ready_toggle) bus_if.tx_ready = ~bus_if.tx_ready;
      else              bus_if.tx_ready = 1'b1;
      #1;
      if (bus_if.fifo_rd_en) begin
        rd_cnt++;
        check("rd_en_while_empty", 64'(bus_if.fifo_empty), 64'd0);
        pend = 1'b1;
      end
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid_held", 64'(bus_if.tx_valid), 64'd1);
        check("stall_data_held", 64'(bus_if.tx_data), 64'(prev_data));
      end
      if (bus_if.tx_valid) begin
        txv_cyc++;
        if (bus_if.tx_ready) begin
          seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %0h expected none", bus_if.tx_data);
          end else begin
            check("tx_byte", 64'(bus_if.tx_data), 64'(exp_q.pop_front()));
          end
        end
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
    end
  end

  initial begin
    int b0, t0, r0, d0, s0;
    rst        = 1'b1;
    dump_start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tx_valid", 64'(bus_if.tx_valid), 64'd0);
    check("rst_rd_en", 64'(bus_if.fifo_rd_en), 64'd0);
    check("rst_tx_data", 64'(bus_if.tx_data), 64'd0);
    check("rst_entry_cnt", 64'(entry_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single entry, transmitter always ready.
    fifo_q.push_back(36'h9_1234_5678);
    push_entry({8'h09, 8'h12, 8'h34, 8'h56, 8'h78}, 5);
    pulse_start();
    wait_done("single", 200);
    check("single_entry_cnt", 64'(entry_cnt), 64'd1);
    check("single_exp_drained", 64'(exp_q.size()), 64'd0);
    check("single_busy_after", 64'(busy), 64'd0);

    // Three entries with tx_ready toggling every cycle.
    ready_toggle = 1'b1;
    fifo_q.push_back(36'h1_0203_0405);
    fifo_q.push_back(36'hF_EDCB_A987);
    fifo_q.push_back(36'h0_FF00_FF00);
    push_entry({8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 5);
    push_entry({8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87}, 5);
    push_entry({8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}, 5);
    pulse_start();
    wait_done("toggle", 500);
    ready_toggle = 1'b0;
    check("toggle_entry_cnt", 64'(entry_cnt), 64'd3);
    check("toggle_exp_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Empty FIFO: one FETCH cycle, no pop, no bytes.
    b0 = busy_cyc; t0 = txv_cyc; r0 = rd_cnt;
    pulse_start();
    wait_done("empty", 50);
    check("empty_busy_cycles", 64'(busy_cyc - b0), 64'd1);
    check("empty_tx_valid_cycles", 64'(txv_cyc - t0), 64'd0);
    check("empty_rd_en_count", 64'(rd_cnt - r0), 64'd0);
    check("empty_entry_cnt", 64'(entry_cnt), 64'd0);

    // dump_start held into the done cycle must not restart the dump.
    d0 = done_cnt;
    dump_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dump_start = 1'b0;
    #3;
    check("done_collision_busy", 64'(busy), 64'd0);
    check("done_collision_done_cnt", 64'(done_cnt - d0), 64'd1);
    @(negedge clk);

    // dump_start while busy is ignored and entry_cnt keeps counting.
    fifo_q.push_back(36'h5_5AA5_5AA5);
    fifo_q.push_back(36'h3_0000_0001);
    push_entry({8'h05, 8'h5A, 8'hA5, 8'h5A, 8'hA5}, 5);
    push_entry({8'h03, 8'h00, 8'h00, 8'h00, 8'h01}, 5);
    s0 = seen;
    pulse_start();
    wait_seen(s0 + 7 + FRAME * 2, 300);
    pulse_start();
    check("busy_restart_entry_cnt", 64'(entry_cnt), 64'd1);
    check("busy_restart_busy", 64'(busy), 64'd1);
    wait_done("busy_restart", 300);
    check("busy_restart_final_cnt", 64'(entry_cnt), 64'd2);
    check("busy_restart_exp_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Reset after the second byte of the first entry; the partial entry is dropped.
    fifo_q.push_back(36'hA_BCDE_F012);
    fifo_q.push_back(36'h1_2345_6789);
    push_entry({8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h12}, 2 - FRAME);
    push_entry({8'h01, 8'h23, 8'h45, 8'h67, 8'h89}, 5);
    s0 = seen;
    d0 = done_cnt;
    pulse_start();
    wait_seen(s0 + 2, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_tx_valid", 64'(bus_if.tx_valid), 64'd0);
    check("abort_tx_data", 64'(bus_if.tx_data), 64'd0);
    check("abort_rd_en", 64'(bus_if.fifo_rd_en), 64'd0);
    check("abort_entry_cnt", 64'(entry_cnt), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_pending_bytes", 64'(exp_q.size()), 64'(5 + FRAME));
    @(negedge clk);
    pulse_start();
    wait_done("resume", 200);
    check("resume_entry_cnt", 64'(entry_cnt), 64'd1);
    check("resume_exp_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

`ifdef LOG_DUMP_FRAME_EN
    // Framed entry: header byte followed by the zero-extended data bytes.
    fifo_q.push_back(36'h0_0000_00FF);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    pulse_start();
    wait_done("frame", 200);
    check("frame_entry_cnt", 64'(entry_cnt), 64'd1);
    check("frame_exp_drained", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
